regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with per-register scoreboard and optional write bypass.

---
 rtl/regfile_mp_sb.sv | 82 ++++++++
 tb/tb_regfile_mp_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard; x0 reads zero and is never busy.
// Reads are combinational (optional same-cycle write bypass), writes/alloc commit on clk; no backpressure.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic                 alloc_en_i,
    input  logic [AW-1:0]        alloc_addr_i,
    output logic [NREG-1:0]      busy_vec_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Lanes are visited in ascending order so the highest index lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                    regs_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
            busy_q <= busy_d;
        end
    end

    // A new producer supersedes an older one completing in the same cycle.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w]) begin
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en_i) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data_o[i*XLEN +: XLEN] = regs_q[rd_addr_i[i*AW +: AW]];
            rd_busy_o[i]              = busy_q[rd_addr_i[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[i*AW +: AW])) begin
                        rd_data_o[i*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
                        rd_busy_o[i]              = 1'b0;
                    end
                end
            end
            if (rd_addr_i[i*AW +: AW] == '0) begin
                rd_data_o[i*XLEN +: XLEN] = '0;
                rd_busy_o[i]              = 1'b0;
            end
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: a bypassing two-lane instance driven from a vector table, plus a
// non-bypassing single-lane instance sharing lane 0 for the next-cycle visibility cases.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        alloc_en = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic [31:0] busy_vec;

    logic [9:0]  nb_rd_addr = '0;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic [31:0] nb_busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(busy_vec)
    );

    regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_i(nb_rd_addr), .rd_data_o(nb_rd_data), .rd_busy_o(nb_rd_busy),
        .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[4:0]), .wr_data_i(wr_data[31:0]),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .busy_vec_o(nb_busy_vec)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] ebv;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic ae, logic [4:0] aa,
                                logic [4:0] ra0, logic [4:0] ra1, logic [31:0] e0,
                                logic [31:0] e1, logic [1:0] eb, logic [31:0] ebv);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ae = ae; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebv = ebv;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;
    endtask

    initial begin
        // we   wa0    wd0           wa1    wd1           ae    aa     ra0    ra1    e0            e1            eb     ebv
        vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0);
        vecs[1]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
        vecs[2]  = mk(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0);
        vecs[4]  = mk(2'b10, 5'd0, 32'h0,        5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 32'h0);
        vecs[5]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00, 32'h0);
        vecs[6]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h0,        32'h0,        2'b11, 32'h200);
        vecs[7]  = mk(2'b01, 5'd9, 32'h1,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h1,        32'h0,        2'b00, 32'h200);
        vecs[8]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h1,        32'h1,        2'b00, 32'h0);
        vecs[9]  = mk(2'b01, 5'd9, 32'h1,        5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h1,        32'h0,        2'b00, 32'h0);
        vecs[10] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h1,        32'h1,        2'b11, 32'h200);
        vecs[11] = mk(2'b11, 5'd3, 32'h11,       5'd3, 32'h22,       1'b0, 5'd0, 5'd3, 5'd9, 32'h22,       32'h1,        2'b10, 32'h200);
        vecs[12] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h22,       32'h0,        2'b00, 32'h200);
        vecs[13] = mk(2'b11, 5'd3, 32'h33,       5'd9, 32'h99,       1'b1, 5'd3, 5'd9, 5'd3, 32'h99,       32'h33,       2'b00, 32'h200);
        vecs[14] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3, 32'h99,       32'h33,       2'b10, 32'h8);

        // Reset held with random write/alloc traffic: nothing may stick.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wr_en = 2'($urandom); wr_addr = 10'($urandom); wr_data = {$urandom, $urandom};
            alloc_en = 1'b1; alloc_addr = 5'($urandom_range(1, 31));
        end
        @(negedge clk);
        idle();
        rd_addr = {5'd17, 5'd5};
        #1;
        check("rst_hold_rd", rd_data, 64'h0);
        check("rst_hold_bv", {32'h0, busy_vec}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rel_rd", rd_data, 64'h0);
        check("rst_rel_bv", {32'h0, busy_vec}, 64'h0);
        check("rst_rel_nb_bv", {32'h0, nb_busy_vec}, 64'h0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we;
            wr_addr = {vecs[i].wa1, vecs[i].wa0};
            wr_data = {vecs[i].wd1, vecs[i].wd0};
            alloc_en = vecs[i].ae;
            alloc_addr = vecs[i].aa;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("v%0d_rd0", i), {32'h0, rd_data[31:0]}, {32'h0, vecs[i].e0});
            check($sformatf("v%0d_rd1", i), {32'h0, rd_data[63:32]}, {32'h0, vecs[i].e1});
            check($sformatf("v%0d_busy", i), {62'h0, rd_busy}, {62'h0, vecs[i].eb});
            check($sformatf("v%0d_bv", i), {32'h0, busy_vec}, {32'h0, vecs[i].ebv});
        end

        // Asynchronous reset mid-cycle with a write pending: state clears at once.
        @(negedge clk);
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hFFFF0000};
        rd_addr = {5'd9, 5'd3};
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_r3", {32'h0, rd_data[31:0]}, 64'h0);
        check("arst_bv", {32'h0, busy_vec}, 64'h0);
        @(posedge clk);
        #1;
        idle();
        rd_addr = {5'd9, 5'd5};
        #1;
        check("arst_rd_r5", rd_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-bypass build: writes show up only after the edge.
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5};
        alloc_en = 1'b1; alloc_addr = 5'd9;
        nb_rd_addr = {5'd9, 5'd7};
        #1;
        check("nb_same_cycle_old", {32'h0, nb_rd_data[31:0]}, 64'h0);
        check("nb_same_cycle_busy", {62'h0, nb_rd_busy}, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("nb_next_cycle_new", {32'h0, nb_rd_data[31:0]}, {32'h0, 32'hA5A5A5A5});
        check("nb_alloc_busy", {62'h0, nb_rd_busy}, {62'h0, 2'b10});
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h5};
        nb_rd_addr = {5'd9, 5'd9};
        #1;
        check("nb_wb_old_data", nb_rd_data, 64'h0);
        check("nb_wb_still_busy", {62'h0, nb_rd_busy}, {62'h0, 2'b11});
        @(negedge clk);
        idle();
        #1;
        check("nb_wb_new_data", nb_rd_data, {32'h5, 32'h5});
        check("nb_wb_cleared", {62'h0, nb_rd_busy}, 64'h0);
        check("nb_bv_cleared", {32'h0, nb_busy_vec}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
